ex_mem_pipe: RTL
================

Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register for the five-stage MIPS core, sitting between the execute and memory-access stages.
- Carries the GPR write triple plus HI/LO write data.
- Adds stall, flush and bubble insertion.
- Holds multi-cycle execute state (accumulator temp and cycle counter) for madd/msub-style two-cycle operations and feeds it back to EX.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data paths
- RADDR_W, 5, GPR address width
- CNT_W, 2, multi-cycle counter width
- NOP_RADDR, 0, register address driven when the slot holds a bubble

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall_ex  in  1  EX stage stalled this cycle (from stall controller)
- stall_mem  in  1  MEM stage stalled this cycle
- flush  in  1  discard EX/MEM contents (exception/redirect)
- ex_rw  in  RADDR_W  GPR destination
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  DATA_W  GPR write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi  in  DATA_W  HI write data
- ex_lo  in  DATA_W  LO write data
- ex_hilo_temp  in  2*DATA_W  partial multi-cycle result from EX
- ex_cnt  in  CNT_W  multi-cycle step count from EX
- mem_rw  out  RADDR_W  registered GPR destination
- mem_wreg  out  1  registered GPR write enable
- mem_wdata  out  DATA_W  registered GPR data
- mem_whilo  out  1  registered HI/LO write enable
- mem_hi  out  DATA_W  registered HI data
- mem_lo  out  DATA_W  registered LO data
- mem_valid  out  1  slot holds a real instruction (0 = bubble)
- hilo_temp_o  out  2*DATA_W  held partial result, fed back to EX
- cnt_o  out  CNT_W  held step count, fed back to EX

Behaviour:
- All registers update on posedge clk only; no combinational input-to-output paths.
- Priority per cycle, highest first: rst > flush > bubble > hold > advance.
- Reset (rst=1): mem_rw=NOP_RADDR; mem_wreg=0; mem_whilo=0; mem_valid=0; mem_wdata, mem_hi, mem_lo, hilo_temp_o=0; cnt_o=0.
- Flush (flush=1): same values as reset, regardless of stall inputs. A flush coincident with rst behaves as rst.
- Bubble (stall_ex=1, stall_mem=0):
  - Pipeline outputs take the reset values (mem_valid=0, write enables 0, mem_rw=NOP_RADDR).
  - hilo_temp_o<=ex_hilo_temp and cnt_o<=ex_cnt, so EX sees its own partial state next cycle.
- Hold (stall_mem=1): every output keeps its value, whatever stall_ex is. hilo_temp_o/cnt_o also hold.
- Advance (stall_ex=0, stall_mem=0):
  - mem_* <= ex_*; mem_valid<=1.
  - hilo_temp_o<=0; cnt_o<=0 (multi-cycle op finished or none in progress).
- Latency is exactly 1 cycle from EX inputs to mem_* outputs when advancing.
- No arithmetic is performed; fields are stored at full declared width.
- hilo_temp_o is split as {hi_part[2*DATA_W-1:DATA_W], lo_part[DATA_W-1:0]} and passes through unmodified.
- Write enables deasserted in a bubble guarantee no GPR/HI/LO side effects downstream, whatever the data fields contain.
- rst or flush asserted mid multi-cycle op clears cnt_o/hilo_temp_o to 0; EX restarts the op from step 0.

Optional Feature:
- Macro: EXMEM_LOADSTORE_EN.
- Defined:
  - Adds ports ex_aluop (in, 8), ex_mem_addr (in, DATA_W), ex_reg2 (in, DATA_W), and registered outputs mem_aluop, mem_addr, mem_reg2.
  - These follow identical reset/flush/bubble/hold/advance rules; reset/bubble value is 0 for all three, so aluop=0 is the NOP op.
- Not defined:
  - Ports and registers are absent.
  - The MEM stage treats every instruction as non-memory.

Test Plan:
- rst=1 two cycles with ex_wreg=1, ex_wdata=0x1234 -> all outputs 0, mem_rw=0, mem_valid=0.
- Advance: ex_rw=5, ex_wreg=1, ex_wdata=0xDEADBEEF, ex_whilo=1, ex_hi=0x1, ex_lo=0x2 -> next cycle mem_* equal inputs, mem_valid=1, cnt_o=0.
- Bubble: stall_ex=1, stall_mem=0, ex_cnt=1, ex_hilo_temp=0x00000001_FFFFFFFF -> mem_wreg=0, mem_whilo=0, mem_valid=0, cnt_o=1, hilo_temp_o=0x00000001_FFFFFFFF. Next advance cycle -> cnt_o=0, hilo_temp_o=0.
- Hold: load ex_wdata=0xAA, then stall_mem=1 for 3 cycles while ex_wdata changes to 0xBB -> mem_wdata stays 0xAA, mem_valid stays 1.
- Flush concurrent with stall_mem=1 and valid slot -> next cycle mem_valid=0, mem_wreg=0, cnt_o=0.
- With EXMEM_LOADSTORE_EN: ex_aluop=0x23, ex_mem_addr=0x1000 advance -> mem_aluop=0x23, mem_addr=0x1000. A bubble cycle -> both 0.

Source files
------------

// File: rtl/ex_mem_pipe_if.sv
// EX/MEM bus: execute-side results in, memory-side registered view out.
// EXMEM_LOADSTORE_EN adds the load/store opcode, address and store data.
interface ex_mem_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 2
);
  logic [RADDR_W-1:0]  ex_rw;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] ex_hilo_temp;
  logic [CNT_W-1:0]    ex_cnt;
  logic [RADDR_W-1:0]  mem_rw;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_valid;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [CNT_W-1:0]    cnt_o;
`ifdef EXMEM_LOADSTORE_EN
  logic [7:0]          ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [7:0]          mem_aluop;
  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
`endif

  modport master (
    output ex_rw, ex_wreg, ex_wdata, ex_whilo,
    output ex_hi, ex_lo, ex_hilo_temp, ex_cnt,
`ifdef EXMEM_LOADSTORE_EN
    output ex_aluop, ex_mem_addr, ex_reg2,
    input  mem_aluop, mem_addr, mem_reg2,
`endif
    input  mem_rw, mem_wreg, mem_wdata, mem_whilo,
    input  mem_hi, mem_lo, mem_valid,
    input  hilo_temp_o, cnt_o
  );

  modport slave (
    input  ex_rw, ex_wreg, ex_wdata, ex_whilo,
    input  ex_hi, ex_lo, ex_hilo_temp, ex_cnt,
`ifdef EXMEM_LOADSTORE_EN
    input  ex_aluop, ex_mem_addr, ex_reg2,
    output mem_aluop, mem_addr, mem_reg2,
`endif
    output mem_rw, mem_wreg, mem_wdata, mem_whilo,
    output mem_hi, mem_lo, mem_valid,
    output hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall, flush, bubble and multi-cycle feedback.
// EXMEM_LOADSTORE_EN adds aluop/address/store-data fields to the slot.
module ex_mem_pipe #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int CNT_W     = 2,
  parameter int NOP_RADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_ex,
  input  logic          stall_mem,
  input  logic          flush,
  ex_mem_pipe_if.slave  bus
);

  typedef struct packed {
    logic [RADDR_W-1:0] rw;
    logic               wreg;
    logic [DATA_W-1:0]  wdata;
    logic               whilo;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;
    logic               valid;
`ifdef EXMEM_LOADSTORE_EN
    logic [7:0]         aluop;
    logic [DATA_W-1:0]  addr;
    logic [DATA_W-1:0]  reg2;
`endif
  } slot_t;

  typedef enum logic [1:0] {
    M_CLR, M_BUB, M_HOLD, M_ADV
  } mode_t;

  slot_t               slot_q, nop_s, ex_s;
  logic [2*DATA_W-1:0] temp_q;
  logic [CNT_W-1:0]    cnt_q;
  mode_t               mode;
  logic                clr, bub, hold;

  always_comb begin
    nop_s    = '0;
    nop_s.rw = RADDR_W'(NOP_RADDR);
  end

  always_comb begin
    ex_s       = '0;
    ex_s.rw    = bus.ex_rw;
    ex_s.wreg  = bus.ex_wreg;
    ex_s.wdata = bus.ex_wdata;
    ex_s.whilo = bus.ex_whilo;
    ex_s.hi    = bus.ex_hi;
    ex_s.lo    = bus.ex_lo;
    ex_s.valid = 1'b1;
`ifdef EXMEM_LOADSTORE_EN
    ex_s.aluop = bus.ex_aluop;
    ex_s.addr  = bus.ex_mem_addr;
    ex_s.reg2  = bus.ex_reg2;
`endif
  end

  // One-hot decode of the priority rst/flush > bubble > hold > advance.
  assign clr  = rst | flush;
  assign bub  = ~clr & stall_ex & ~stall_mem;
  assign hold = ~clr & stall_mem;

  always_comb begin
    mode = M_ADV;
    unique case (1'b1)
      clr:     mode = M_CLR;
      bub:     mode = M_BUB;
      hold:    mode = M_HOLD;
      default: mode = M_ADV;
    endcase
  end

  always_ff @(posedge clk) begin
    unique case (mode)
      M_CLR: begin
        slot_q <= nop_s;
        temp_q <= '0;
        cnt_q  <= '0;
      end
      M_BUB: begin
        slot_q <= nop_s;
        temp_q <= bus.ex_hilo_temp;
        cnt_q  <= bus.ex_cnt;
      end
      M_HOLD: begin
        slot_q <= slot_q;
        temp_q <= temp_q;
        cnt_q  <= cnt_q;
      end
      default: begin
        slot_q <= ex_s;
        temp_q <= '0;
        cnt_q  <= '0;
      end
    endcase
  end

  assign bus.mem_rw      = slot_q.rw;
  assign bus.mem_wreg    = slot_q.wreg;
  assign bus.mem_wdata   = slot_q.wdata;
  assign bus.mem_whilo   = slot_q.whilo;
  assign bus.mem_hi      = slot_q.hi;
  assign bus.mem_lo      = slot_q.lo;
  assign bus.mem_valid   = slot_q.valid;
  assign bus.hilo_temp_o = temp_q;
  assign bus.cnt_o       = cnt_q;
`ifdef EXMEM_LOADSTORE_EN
  assign bus.mem_aluop   = slot_q.aluop;
  assign bus.mem_addr    = slot_q.addr;
  assign bus.mem_reg2    = slot_q.reg2;
`endif

endmodule
